write_back_stage: RTL and testbench

- Parametrised MEM/WB pipeline stage for the MIPS core. Sits between the data-memory block and the register file.
- Registers the DM-stage bundle, honouring valid, stall and flush. Selects ALU result or load data, then applies byte/half extension to the load data.
- Drives the register-file write port and the forwarding bus, and keeps a retired-instruction counter.

---
 rtl/write_back_stage.sv | 136 +++++++++++++
 tb/tb_write_back_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_stage.sv
// rtl/write_back_stage.sv - MEM/WB pipeline register with load extension, register-file write port and retire counter
module write_back_stage #(
    parameter int DATA_W = 16,
    parameter int BOFF_W = 1,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_write,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [2:0]        in_ld_mode,
    input  logic [BOFF_W-1:0] in_byte_off,
    input  logic              stall,
    input  logic              flush,
    output logic              in_ready,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int NBYTES = DATA_W / 8;
    localparam int NHALFS = DATA_W / 16;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mem_q, mem_d;
    logic              m2r_q, m2r_d;
    logic              rw_q, rw_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [2:0]        mode_q, mode_d;
    logic [BOFF_W-1:0] off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;

    always_comb begin
        valid_d = valid_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        m2r_d   = m2r_q;
        rw_d    = rw_q;
        rd_d    = rd_q;
        mode_d  = mode_q;
        off_d   = off_q;
        cnt_d   = cnt_q;

        // An instruction retires when it leaves the WB register.
        if (valid_q && !stall) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Fields also load on flush; their contents are irrelevant once valid drops.
        if (flush || !stall) begin
            alu_d  = in_alu_res;
            mem_d  = in_mem_data;
            m2r_d  = in_mem_to_reg;
            rw_d   = in_reg_write;
            rd_d   = in_rd;
            mode_d = in_ld_mode;
            off_d  = in_byte_off;
        end

        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            mem_q   <= '0;
            m2r_q   <= 1'b0;
            rw_q    <= 1'b0;
            rd_q    <= '0;
            mode_q  <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            mem_q   <= mem_d;
            m2r_q   <= m2r_d;
            rw_q    <= rw_d;
            rd_q    <= rd_d;
            mode_q  <= mode_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ld_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (off_q == BOFF_W'(k)) begin
                ld_byte = mem_q[8*k +: 8];
            end
        end
        ld_half = '0;
        for (int h = 0; h < NHALFS; h++) begin
            if ((off_q >> 1) == BOFF_W'(h)) begin
                ld_half = mem_q[16*h +: 16];
            end
        end
    end

    always_comb begin
        ld_data = mem_q;
        case (mode_q)
            3'b001:  ld_data = DATA_W'($signed(ld_byte));
            3'b010:  ld_data = DATA_W'(ld_byte);
            3'b011:  ld_data = DATA_W'($signed(ld_half));
            3'b100:  ld_data = DATA_W'(ld_half);
            default: ld_data = mem_q;
        endcase
    end

    assign in_ready   = !stall;
    assign wb_valid   = valid_q;
    assign wb_we      = valid_q && rw_q && (rd_q != '0);
    assign wb_rd      = rd_q;
    assign wb_data    = m2r_q ? ld_data : alu_q;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_write_back_stage.sv
// tb/tb_write_back_stage.sv - vector table, corner sequences and randomized model check for write_back_stage
module tb_write_back_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid;
    logic [15:0] in_alu_res;
    logic [15:0] in_mem_data;
    logic        in_mem_to_reg;
    logic        in_reg_write;
    logic [2:0]  in_rd;
    logic [2:0]  in_ld_mode;
    logic [0:0]  in_byte_off;
    logic        stall;
    logic        flush;

    logic        in_ready, wb_valid, wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [15:0] retire_cnt;

    logic        in_ready4, wb_valid4, wb_we4;
    logic [2:0]  wb_rd4;
    logic [15:0] wb_data4;
    logic [3:0]  retire_cnt4;

    write_back_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_alu_res(in_alu_res),
        .in_mem_data(in_mem_data), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_rd(in_rd), .in_ld_mode(in_ld_mode), .in_byte_off(in_byte_off),
        .stall(stall), .flush(flush), .in_ready(in_ready), .wb_valid(wb_valid),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .retire_cnt(retire_cnt)
    );

    write_back_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_alu_res(in_alu_res),
        .in_mem_data(in_mem_data), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_rd(in_rd), .in_ld_mode(in_ld_mode), .in_byte_off(in_byte_off),
        .stall(stall), .flush(flush), .in_ready(in_ready4), .wb_valid(wb_valid4),
        .wb_we(wb_we4), .wb_rd(wb_rd4), .wb_data(wb_data4), .retire_cnt(retire_cnt4)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: what the WB register should hold, plus total retirements.
    bit          m_valid, m_m2r, m_rw;
    logic [2:0]  m_rd, m_mode;
    logic [15:0] m_alu, m_mem;
    int          m_off;
    int unsigned m_cnt;

    typedef struct {
        logic        v;
        logic [15:0] alu;
        logic [15:0] mem;
        logic        m2r;
        logic        rw;
        logic [2:0]  rd;
        logic [2:0]  mode;
        logic        off;
        logic        ev;
        logic        ewe;
        logic [15:0] ed;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic v, logic [15:0] alu, logic [15:0] mem, logic m2r, logic rw,
                                logic [2:0] rd, logic [2:0] mode, logic off,
                                logic ev, logic ewe, logic [15:0] ed, logic [15:0] ecnt);
        vec_t r;
        r.v = v; r.alu = alu; r.mem = mem; r.m2r = m2r; r.rw = rw; r.rd = rd;
        r.mode = mode; r.off = off; r.ev = ev; r.ewe = ewe; r.ed = ed; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // At 16 bits a halfword load covers the whole word, so LH/LHU return it unchanged.
    function automatic logic [15:0] model_data();
        int b;
        if (!m_m2r) return m_alu;
        b = (int'(m_mem) >> (8 * m_off)) & 255;
        case (m_mode)
            3'd1:    return (b >= 128) ? 16'(b + 65280) : 16'(b);
            3'd2:    return 16'(b);
            default: return m_mem;
        endcase
    endfunction

    task automatic check_model();
        logic exp_we;
        exp_we = m_valid && m_rw && (m_rd != 3'd0);
        chk("wb_valid", wb_valid, m_valid);
        chk("wb_we", wb_we, exp_we);
        chk("in_ready", in_ready, !stall);
        chk("retire_cnt", retire_cnt, m_cnt % 65536);
        chk("wb_valid4", wb_valid4, m_valid);
        chk("wb_we4", wb_we4, exp_we);
        chk("in_ready4", in_ready4, !stall);
        chk("retire_cnt4", retire_cnt4, m_cnt % 16);
        if (m_valid) begin
            chk("wb_rd", wb_rd, m_rd);
            chk("wb_data", wb_data, model_data());
            chk("wb_rd4", wb_rd4, m_rd);
            chk("wb_data4", wb_data4, model_data());
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (m_valid && !stall) m_cnt++;
        if (flush) begin
            m_valid = 1'b0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_alu = in_alu_res; m_mem = in_mem_data; m_m2r = in_mem_to_reg;
            m_rw = in_reg_write; m_rd = in_rd; m_mode = in_ld_mode; m_off = int'(in_byte_off);
        end
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_alu_res = '0; in_mem_data = '0; in_mem_to_reg = 0;
        in_reg_write = 0; in_rd = '0; in_ld_mode = '0; in_byte_off = '0;
        stall = 0; flush = 0;
    endtask

    task automatic model_clear();
        m_valid = 0; m_m2r = 0; m_rw = 0; m_rd = '0; m_mode = '0;
        m_alu = '0; m_mem = '0; m_off = 0; m_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic drive_alu(input logic v, input logic [2:0] rd, input logic [15:0] alu);
        in_valid = v; in_reg_write = 1; in_rd = rd; in_alu_res = alu;
        in_mem_to_reg = 0; in_ld_mode = '0; in_byte_off = '0;
    endtask

    int base;

    initial begin
        tbl[0]  = mk(1, 16'h1234, 16'h0000, 0, 1, 3'd5, 3'd0, 0, 1, 1, 16'h1234, 16'd0);
        tbl[1]  = mk(1, 16'h0000, 16'h80F1, 1, 1, 3'd1, 3'd1, 0, 1, 1, 16'hFFF1, 16'd1);
        tbl[2]  = mk(1, 16'h0000, 16'h80F1, 1, 1, 3'd2, 3'd2, 1, 1, 1, 16'h0080, 16'd2);
        tbl[3]  = mk(1, 16'h0000, 16'h80F1, 1, 1, 3'd3, 3'd1, 1, 1, 1, 16'hFF80, 16'd3);
        tbl[4]  = mk(1, 16'h0000, 16'h80F1, 1, 1, 3'd4, 3'd7, 0, 1, 1, 16'h80F1, 16'd4);
        tbl[5]  = mk(1, 16'h0000, 16'h80F1, 1, 1, 3'd5, 3'd3, 1, 1, 1, 16'h80F1, 16'd5);
        tbl[6]  = mk(1, 16'h0000, 16'h7F01, 1, 1, 3'd6, 3'd4, 0, 1, 1, 16'h7F01, 16'd6);
        tbl[7]  = mk(1, 16'h0000, 16'h7F01, 1, 1, 3'd7, 3'd1, 1, 1, 1, 16'h007F, 16'd7);
        tbl[8]  = mk(1, 16'h5555, 16'h0000, 0, 1, 3'd0, 3'd0, 0, 1, 0, 16'h5555, 16'd8);
        tbl[9]  = mk(0, 16'h0BAD, 16'h0000, 0, 1, 3'd6, 3'd0, 0, 0, 0, 16'h0BAD, 16'd9);
        tbl[10] = mk(1, 16'h4321, 16'h0000, 0, 0, 3'd7, 3'd0, 0, 1, 0, 16'h4321, 16'd9);
        tbl[11] = mk(1, 16'h0000, 16'h8001, 1, 1, 3'd1, 3'd5, 1, 1, 1, 16'h8001, 16'd10);
        tbl[12] = mk(1, 16'h80F1, 16'h0000, 0, 1, 3'd2, 3'd1, 0, 1, 1, 16'h80F1, 16'd11);

        do_reset();
        chk("rst_valid", wb_valid, 0);
        chk("rst_we", wb_we, 0);
        chk("rst_rd", wb_rd, 0);
        chk("rst_data", wb_data, 16'h0000);
        chk("rst_cnt", retire_cnt, 0);
        step();

        for (int i = 0; i < 13; i++) begin
            in_valid = tbl[i].v; in_alu_res = tbl[i].alu; in_mem_data = tbl[i].mem;
            in_mem_to_reg = tbl[i].m2r; in_reg_write = tbl[i].rw; in_rd = tbl[i].rd;
            in_ld_mode = tbl[i].mode; in_byte_off = tbl[i].off; stall = 0; flush = 0;
            step();
            chk($sformatf("vec%0d_valid", i), wb_valid, tbl[i].ev);
            chk($sformatf("vec%0d_we", i), wb_we, tbl[i].ewe);
            chk($sformatf("vec%0d_rd", i), wb_rd, tbl[i].rd);
            chk($sformatf("vec%0d_data", i), wb_data, tbl[i].ed);
            chk($sformatf("vec%0d_cnt", i), retire_cnt, tbl[i].ecnt);
        end

        // Stall holds the entry for three cycles and it retires exactly once.
        drive_alu(1, 3'd2, 16'h00AA);
        step();
        base = int'(m_cnt);
        chk("stall_load_data", wb_data, 16'h00AA);
        stall = 1;
        drive_alu(1, 3'd7, 16'h1111);
        repeat (3) begin
            step();
            chk("stall_rd", wb_rd, 3'd2);
            chk("stall_data", wb_data, 16'h00AA);
            chk("stall_we", wb_we, 1);
            chk("stall_cnt", retire_cnt, 16'(base));
            chk("stall_ready", in_ready, 0);
        end
        stall = 0;
        in_valid = 0;
        step();
        chk("stall_retire_once", retire_cnt, 16'(base + 1));
        chk("stall_release_valid", wb_valid, 0);

        // Flush beats stall.
        drive_alu(1, 3'd3, 16'h0033);
        step();
        base = int'(m_cnt);
        stall = 1; flush = 1;
        drive_alu(1, 3'd4, 16'h0044);
        step();
        chk("flush_valid", wb_valid, 0);
        chk("flush_we", wb_we, 0);
        chk("flush_cnt", retire_cnt, 16'(base));
        stall = 0; flush = 0; in_valid = 0;
        step();
        chk("flush_bubble_cnt", retire_cnt, 16'(base));

        // Asynchronous reset with a live entry, sampled between clock edges.
        drive_alu(1, 3'd5, 16'hABCD);
        step();
        chk("pre_rst_valid", wb_valid, 1);
        #2;
        reset = 0;
        #1;
        chk("async_rst_valid", wb_valid, 0);
        chk("async_rst_we", wb_we, 0);
        chk("async_rst_rd", wb_rd, 0);
        chk("async_rst_data", wb_data, 16'h0000);
        chk("async_rst_cnt", retire_cnt, 0);
        do_reset();

        // 17 retirements wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            drive_alu(1, 3'd1, 16'(i));
            step();
        end
        in_valid = 0;
        step();
        chk("wrap_cnt4", retire_cnt4, 4'd1);
        chk("wrap_cnt16", retire_cnt, 16'd17);

        for (int i = 0; i < 400; i++) begin
            in_valid      = 1'($urandom_range(0, 1));
            in_alu_res    = 16'($urandom);
            in_mem_data   = 16'($urandom);
            in_mem_to_reg = 1'($urandom_range(0, 1));
            in_reg_write  = 1'($urandom_range(0, 1));
            in_rd         = 3'($urandom_range(0, 7));
            in_ld_mode    = 3'($urandom_range(0, 7));
            in_byte_off   = 1'($urandom_range(0, 1));
            stall         = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
